// File: rtl/axis_serdes_pkg.sv
// Shared definitions for the axis_serdes bridge family: arbiter state encoding and a
// constant-evaluable ceil(log2) helper.
package axis_serdes_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StData = 2'd2
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first asserted request at or after ptr, modulo NUM_REQ.
// The ptr input is expected to be below NUM_REQ.
module rr_arbiter_comb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] idx
);

    localparam int unsigned SW = IDX_WIDTH + 1;

    logic [SW-1:0] sum;

    always_comb begin
        valid = |req;
        idx   = '0;
        sum   = '0;
        // Scan farthest offset first so the nearest request at/after ptr overwrites last.
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + SW'(off);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            if (req[sum[IDX_WIDTH-1:0]]) begin
                idx = sum[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_serdes_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the bridge S_AW*/S_W* slave port among NUM_REQ
// requesters. Define ARB_BEAT_CHECK_EN to add AWLEN beat checking (ERR_O, ERR_STICKY_O).
module axis_serdes_tx_arbiter
    import axis_serdes_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned AWPORT_WIDTH = 2,
    parameter int unsigned AWLEN_WIDTH  = 16,
    parameter int unsigned AWSIZE_WIDTH = 16
) (
    input  logic                                CLK_I,
    input  logic                                RST_I,
    input  logic [NUM_REQ*AWLEN_WIDTH-1:0]      S_AWLEN,
    input  logic [NUM_REQ*AWSIZE_WIDTH-1:0]     S_AWSIZE,
    input  logic [NUM_REQ-1:0]                  S_AWVALID,
    output logic [NUM_REQ-1:0]                  S_AWREADY,
    input  logic [NUM_REQ-1:0]                  S_WVALID,
    output logic [NUM_REQ-1:0]                  S_WREADY,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       S_WDATA,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   S_WSTRB,
    input  logic [NUM_REQ-1:0]                  S_WLAST,
    output logic [AWPORT_WIDTH-1:0]             M_AWPORT,
    output logic [AWLEN_WIDTH-1:0]              M_AWLEN,
    output logic [AWSIZE_WIDTH-1:0]             M_AWSIZE,
    output logic                                M_AWVALID,
    input  logic                                M_AWREADY,
    output logic                                M_WVALID,
    input  logic                                M_WREADY,
    output logic [DATA_WIDTH-1:0]               M_WDATA,
    output logic [DATA_WIDTH/8-1:0]             M_WSTRB,
    output logic                                M_WLAST,
    output logic [NUM_REQ-1:0]                  GRANT_O,
    output logic                                BUSY_O
`ifdef ARB_BEAT_CHECK_EN
    ,
    output logic                                ERR_O,
    output logic                                ERR_STICKY_O
`endif
);

    localparam int unsigned IDX_WIDTH  = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_e             state_q, state_d;
    logic [IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                   pick_valid;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic                   aw_hs, w_hs, wlast_eff;

    logic [AWLEN_WIDTH-1:0]  awlen_arr  [NUM_REQ];
    logic [AWSIZE_WIDTH-1:0] awsize_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr  [NUM_REQ];
    logic [STRB_WIDTH-1:0]   wstrb_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign awlen_arr[i]  = S_AWLEN[i*AWLEN_WIDTH +: AWLEN_WIDTH];
        assign awsize_arr[i] = S_AWSIZE[i*AWSIZE_WIDTH +: AWSIZE_WIDTH];
        assign wdata_arr[i]  = S_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_arr[i]  = S_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
    end

    rr_arbiter_comb #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (S_AWVALID),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign aw_hs = (state_q == StCmd) && S_AWVALID[grant_q] && M_AWREADY;
    assign w_hs  = (state_q == StData) && S_WVALID[grant_q] && M_WREADY;

`ifdef ARB_BEAT_CHECK_EN
    logic [AWLEN_WIDTH-1:0] beat_cnt_q, awlen_q;
    logic                   err_q, err_sticky_q, beat_final;

    // Reaching AWLEN terminates the burst even if the requester forgot WLAST.
    assign beat_final = (beat_cnt_q + 1'b1) == awlen_q;
    assign wlast_eff  = S_WLAST[grant_q] | beat_final;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            beat_cnt_q   <= '0;
            awlen_q      <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            err_q <= w_hs && (S_WLAST[grant_q] ^ beat_final);
            if (w_hs && (S_WLAST[grant_q] ^ beat_final)) begin
                err_sticky_q <= 1'b1;
            end
            if (aw_hs) begin
                awlen_q    <= awlen_arr[grant_q];
                beat_cnt_q <= '0;
            end else if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign ERR_O        = err_q;
    assign ERR_STICKY_O = err_sticky_q;
`else
    assign wlast_eff = S_WLAST[grant_q];
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        S_AWREADY = '0;
        S_WREADY  = '0;
        M_AWPORT  = '0;
        M_AWLEN   = '0;
        M_AWSIZE  = '0;
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_WLAST   = 1'b0;
        GRANT_O   = '0;
        BUSY_O    = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                GRANT_O[grant_q]   = 1'b1;
                M_AWVALID          = S_AWVALID[grant_q];
                M_AWPORT           = AWPORT_WIDTH'(grant_q);
                M_AWLEN            = awlen_arr[grant_q];
                M_AWSIZE           = awsize_arr[grant_q];
                S_AWREADY[grant_q] = M_AWREADY;
                if (aw_hs) begin
                    state_d = StData;
                end else if (!S_AWVALID[grant_q]) begin
                    // Withdrawn command: re-arbitrate without advancing the pointer.
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
            StData: begin
                GRANT_O[grant_q]  = 1'b1;
                M_WVALID          = S_WVALID[grant_q];
                M_WDATA           = wdata_arr[grant_q];
                M_WSTRB           = wstrb_arr[grant_q];
                M_WLAST           = wlast_eff;
                S_WREADY[grant_q] = M_WREADY;
                if (w_hs && wlast_eff) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    rr_ptr_d = (grant_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_serdes_tx_arbiter.sv
// Self-checking bench for axis_serdes_tx_arbiter: vector table, directed corner sequences and
// a randomized run against a queue-level round-robin model.
module tb_axis_serdes_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SB = DW / 8;
    localparam int LW = 16;
    localparam int ZW = 16;
    localparam int PW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*LW-1:0]   s_awlen;
    logic [N*ZW-1:0]   s_awsize;
    logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic [N*DW-1:0]   s_wdata;
    logic [N*SB-1:0]   s_wstrb;
    logic [PW-1:0]     m_awport;
    logic [LW-1:0]     m_awlen;
    logic [ZW-1:0]     m_awsize;
    logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [DW-1:0]     m_wdata;
    logic [SB-1:0]     m_wstrb;
    logic [N-1:0]      grant_o;
    logic              busy_o;
`ifdef ARB_BEAT_CHECK_EN
    logic              err_o, err_sticky_o;
`endif

    logic [LW-1:0] awlen_r  [N];
    logic [ZW-1:0] awsize_r [N];
    logic [DW-1:0] wdata_r  [N];
    logic [SB-1:0] wstrb_r  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_awlen[i*LW +: LW]  = awlen_r[i];
            s_awsize[i*ZW +: ZW] = awsize_r[i];
            s_wdata[i*DW +: DW]  = wdata_r[i];
            s_wstrb[i*SB +: SB]  = wstrb_r[i];
        end
    end

    axis_serdes_tx_arbiter dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .S_AWLEN      (s_awlen),
        .S_AWSIZE     (s_awsize),
        .S_AWVALID    (s_awvalid),
        .S_AWREADY    (s_awready),
        .S_WVALID     (s_wvalid),
        .S_WREADY     (s_wready),
        .S_WDATA      (s_wdata),
        .S_WSTRB      (s_wstrb),
        .S_WLAST      (s_wlast),
        .M_AWPORT     (m_awport),
        .M_AWLEN      (m_awlen),
        .M_AWSIZE     (m_awsize),
        .M_AWVALID    (m_awvalid),
        .M_AWREADY    (m_awready),
        .M_WVALID     (m_wvalid),
        .M_WREADY     (m_wready),
        .M_WDATA      (m_wdata),
        .M_WSTRB      (m_wstrb),
        .M_WLAST      (m_wlast),
        .GRANT_O      (grant_o),
        .BUSY_O       (busy_o)
`ifdef ARB_BEAT_CHECK_EN
        ,
        .ERR_O        (err_o),
        .ERR_STICKY_O (err_sticky_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int g, input int b);
        return {16'hbeef, 16'(g), 16'(b), 16'h1234};
    endfunction

    task automatic clear_inputs();
        s_awvalid = '0;
        s_wvalid  = '0;
        s_wlast   = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            awlen_r[i]  = LW'(1);
            awsize_r[i] = ZW'(8);
            wdata_r[i]  = '0;
            wstrb_r[i]  = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the command of requester g, accept it, then send nbeats beats.
    task automatic serve(input string nm, input int g, input int nbeats, input bit drop_all);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            m_awready  = 1'b1;
            awlen_r[g] = LW'(nbeats);
            #1;
            seen = m_awvalid;
        end
        check({nm, " awvalid"}, 64'(seen), 64'd1);
        check({nm, " awport"}, 64'(m_awport), 64'(g));
        check({nm, " grant"}, 64'(grant_o), 64'(1 << g));
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            s_awvalid[g] = 1'b0;
            s_wvalid[g]  = 1'b1;
            wdata_r[g]   = pat(g, b);
            wstrb_r[g]   = 8'hff;
            s_wlast[g]   = (b == nbeats - 1);
            m_wready     = 1'b1;
            #1;
            check({nm, " wdata"}, m_wdata, pat(g, b));
            check({nm, " wlast"}, 64'(m_wlast), 64'(b == nbeats - 1));
            check({nm, " wready"}, 64'(s_wready), 64'(1 << g));
        end
        @(negedge clk);
        s_wvalid = '0;
        s_wlast  = '0;
        if (drop_all) s_awvalid = '0;
        #1;
        check({nm, " idle"}, 64'(busy_o), 64'd0);
        check({nm, " grant clr"}, 64'(grant_o), 64'd0);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int           port;
    } vec_t;
    vec_t vecs [7];

    // Random-run model: pending packets per requester and a round-robin pointer.
    logic [N-1:0] pend;
    int           plen  [N];
    logic [ZW-1:0] psize [N];
    logic [DW-1:0] pdat  [N][4];
    logic [SB-1:0] pstrb [N][4];
    int           ptr, owner, beat, pkts, exp_g;

    function automatic int rr_pick(input logic [N-1:0] p, input int from);
        for (int k = 0; k < N; k++) begin
            if (p[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic refill();
        for (int j = 0; j < N; j++) begin
            if (!pend[j] && $urandom_range(0, 1) == 1) begin
                pend[j]     = 1'b1;
                plen[j]     = int'($urandom_range(1, 4));
                psize[j]    = ZW'(plen[j] * 8 - int'($urandom_range(0, 7)));
                awlen_r[j]  = LW'(plen[j]);
                awsize_r[j] = psize[j];
                for (int b = 0; b < 4; b++) begin
                    pdat[j][b]  = {$urandom, $urandom};
                    pstrb[j][b] = SB'($urandom);
                end
            end
        end
    endtask

    initial begin
        logic [3:0] wr_pat;
        int         b;

        rst = 1'b1;
        clear_inputs();
        s_awvalid = '1;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst grant", 64'(grant_o), 64'd0);
        check("rst awvalid", 64'(m_awvalid), 64'd0);
        check("rst wvalid", 64'(m_wvalid), 64'd0);
        check("rst awready", 64'(s_awready), 64'd0);
        check("rst wready", 64'(s_wready), 64'd0);
        check("rst awport", 64'(m_awport), 64'd0);
        check("rst wlast", 64'(m_wlast), 64'd0);
        do_reset();

        // Vector table: pointer starts at 0 and advances past each winner.
        vecs[0] = '{mask: 4'b0100, port: 2};
        vecs[1] = '{mask: 4'b0011, port: 0};
        vecs[2] = '{mask: 4'b1111, port: 1};
        vecs[3] = '{mask: 4'b1001, port: 3};
        vecs[4] = '{mask: 4'b1010, port: 1};
        vecs[5] = '{mask: 4'b0001, port: 0};
        vecs[6] = '{mask: 4'b1000, port: 3};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            s_awvalid = vecs[i].mask;
            serve($sformatf("vec%0d", i), vecs[i].port, 1, 1'b1);
        end

        // Single requester 2, two beats with explicit data and strobes.
        do_reset();
        @(negedge clk);
        s_awvalid[2] = 1'b1;
        awlen_r[2]   = LW'(2);
        awsize_r[2]  = ZW'(11);
        #1;
        check("single latency", 64'(m_awvalid), 64'd0);
        @(negedge clk);
        m_awready = 1'b1;
        #1;
        check("single awvalid", 64'(m_awvalid), 64'd1);
        check("single awport", 64'(m_awport), 64'd2);
        check("single awlen", 64'(m_awlen), 64'd2);
        check("single awsize", 64'(m_awsize), 64'd11);
        check("single awready", 64'(s_awready), 64'b0100);
        @(negedge clk);
        s_awvalid[2] = 1'b0;
        s_wvalid[2]  = 1'b1;
        wdata_r[2]   = 64'hee0700aa0100a5a5;
        wstrb_r[2]   = 8'hff;
        s_wlast[2]   = 1'b0;
        m_wready     = 1'b1;
        #1;
        check("single b1 data", m_wdata, 64'hee0700aa0100a5a5);
        check("single b1 strb", 64'(m_wstrb), 64'hff);
        check("single b1 last", 64'(m_wlast), 64'd0);
        check("single b1 wready", 64'(s_wready), 64'b0100);
        @(negedge clk);
        wdata_r[2] = 64'h0000000000cc0201;
        wstrb_r[2] = 8'h07;
        s_wlast[2] = 1'b1;
        #1;
        check("single b2 data", m_wdata, 64'h0000000000cc0201);
        check("single b2 strb", 64'(m_wstrb), 64'h07);
        check("single b2 last", 64'(m_wlast), 64'd1);
        @(negedge clk);
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        check("single grant clr", 64'(grant_o), 64'd0);
        check("single wvalid clr", 64'(m_wvalid), 64'd0);

        // All four requesting: rotation 0,1,2,3 then 0 again after it re-requests.
        do_reset();
        @(negedge clk);
        s_awvalid = 4'b1111;
        serve("rot0", 0, 1, 1'b0);
        s_awvalid[0] = 1'b1;
        serve("rot1", 1, 1, 1'b0);
        serve("rot2", 2, 1, 1'b0);
        serve("rot3", 3, 1, 1'b0);
        serve("rot0b", 0, 1, 1'b1);

        // M_WREADY 1-0-1-1 over a 3-beat burst while requester 1 waits.
        do_reset();
        @(negedge clk);
        s_awvalid  = 4'b0011;
        awlen_r[0] = LW'(3);
        m_awready  = 1'b1;
        @(negedge clk);
        #1;
        check("stall awport", 64'(m_awport), 64'd0);
        wr_pat = 4'b1101;
        b = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            s_awvalid[0] = 1'b0;
            s_wvalid[0]  = 1'b1;
            wdata_r[0]   = pat(0, b);
            wstrb_r[0]   = 8'hff;
            s_wlast[0]   = (b == 2);
            m_wready     = wr_pat[c];
            #1;
            check($sformatf("stall wready c%0d", c), 64'(s_wready), wr_pat[c] ? 64'b0001 : 64'd0);
            check($sformatf("stall data c%0d", c), m_wdata, pat(0, b));
            check($sformatf("stall other c%0d", c), 64'(s_awready), 64'd0);
            check($sformatf("stall grant c%0d", c), 64'(grant_o), 64'b0001);
            if (wr_pat[c]) b++;
        end
        @(negedge clk);
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        check("stall done", 64'(busy_o), 64'd0);
        serve("stall next", 1, 1, 1'b1);

        // Reset in DATA after beat 1; pointer must return to 0.
        do_reset();
        @(negedge clk);
        s_awvalid[1] = 1'b1;
        serve("prerst", 1, 1, 1'b1);
        s_awvalid[2] = 1'b1;
        awlen_r[2]   = LW'(2);
        @(negedge clk);
        m_awready = 1'b1;
        #1;
        check("rstmid awport", 64'(m_awport), 64'd2);
        @(negedge clk);
        s_awvalid[2] = 1'b0;
        s_wvalid[2]  = 1'b1;
        wdata_r[2]   = pat(2, 0);
        m_wready     = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_wvalid = '0;
        #1;
        check("rstmid busy", 64'(busy_o), 64'd0);
        check("rstmid grant", 64'(grant_o), 64'd0);
        check("rstmid wvalid", 64'(m_wvalid), 64'd0);
        check("rstmid wready", 64'(s_wready), 64'd0);
        check("rstmid awvalid", 64'(m_awvalid), 64'd0);
        s_awvalid = 4'b1010;
        serve("postrst", 1, 1, 1'b1);

        // Withdrawn command: pointer stays at 3, so 3 beats 2.
        do_reset();
        @(negedge clk);
        s_awvalid[2] = 1'b1;
        serve("prewd", 2, 1, 1'b1);
        s_awvalid[1] = 1'b1;
        m_awready    = 1'b0;
        @(negedge clk);
        m_awready = 1'b0;
        #1;
        check("wd awport", 64'(m_awport), 64'd1);
        check("wd awready", 64'(s_awready), 64'd0);
        @(negedge clk);
        s_awvalid[1] = 1'b0;
        #1;
        check("wd awvalid drop", 64'(m_awvalid), 64'd0);
        @(negedge clk);
        s_awvalid = 4'b1100;
        #1;
        check("wd idle", 64'(busy_o), 64'd0);
        serve("after wd", 3, 1, 1'b1);

`ifdef ARB_BEAT_CHECK_EN
        // AWLEN=3 but WLAST on beat 2.
        do_reset();
        @(negedge clk);
        s_awvalid[0] = 1'b1;
        awlen_r[0]   = LW'(3);
        @(negedge clk);
        m_awready = 1'b1;
        #1;
        check("chk awport", 64'(m_awport), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_awvalid[0] = 1'b0;
            s_wvalid[0]  = 1'b1;
            s_wlast[0]   = (k == 1);
            m_wready     = 1'b1;
            #1;
            check($sformatf("chk err b%0d", k), 64'(err_o), 64'd0);
        end
        @(negedge clk);
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        check("chk err pulse", 64'(err_o), 64'd1);
        check("chk sticky", 64'(err_sticky_o), 64'd1);
        check("chk released", 64'(busy_o), 64'd0);
        @(negedge clk);
        #1;
        check("chk err end", 64'(err_o), 64'd0);
        check("chk sticky hold", 64'(err_sticky_o), 64'd1);
`endif

        // Randomized traffic against the round-robin model.
        do_reset();
        pend  = '0;
        ptr   = 0;
        owner = -1;
        beat  = 0;
        pkts  = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (owner < 0 && pend == '0) refill();
            for (int j = 0; j < N; j++) begin
                s_awvalid[j] = pend[j] && (owner != j);
                s_wvalid[j]  = (owner == j) && ($urandom_range(0, 3) != 0);
                s_wlast[j]   = (owner == j) && (beat == plen[j] - 1);
                if (owner == j) begin
                    wdata_r[j] = pdat[j][beat];
                    wstrb_r[j] = pstrb[j][beat];
                end
            end
            m_awready = ($urandom_range(0, 1) == 1);
            m_wready  = ($urandom_range(0, 2) != 0);
            #1;
            if (m_awvalid && m_awready) begin
                exp_g = rr_pick(pend, ptr);
                check("rand awport", 64'(m_awport), 64'(exp_g));
                if (exp_g >= 0) begin
                    check("rand awlen", 64'(m_awlen), 64'(plen[exp_g]));
                    check("rand awsize", 64'(m_awsize), 64'(psize[exp_g]));
                    owner = exp_g;
                    beat  = 0;
                end
            end
            if (m_wvalid && m_wready) begin
                if (owner < 0) begin
                    check("rand stray w", 64'(m_wvalid), 64'd0);
                end else begin
                    check("rand wdata", m_wdata, pdat[owner][beat]);
                    check("rand wstrb", 64'(m_wstrb), 64'(pstrb[owner][beat]));
                    check("rand wlast", 64'(m_wlast), 64'(beat == plen[owner] - 1));
                    check("rand wready", 64'(s_wready), 64'(1 << owner));
                    beat++;
                    if (beat == plen[owner]) begin
                        pend[owner] = 1'b0;
                        ptr         = (owner + 1) % N;
                        owner       = -1;
                        pkts++;
                        refill();
                    end
                end
            end
        end
        check("rand progress", 64'(pkts >= 40), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_serdes_tx_arbiter.md
Name: axis_serdes_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single AXI4-Stream-style write slave port of the axi4stream2serdes bridge between NUM_REQ independent requesters. Each requester presents an AW command (port, length, size) followed by a W burst terminated by WLAST. The arbiter grants one requester at a time and forwards its AW command and then its complete W burst. It releases the grant only after the last beat handshake. It sits in the S_CLK_I domain, directly upstream of the bridge's S_AW*/S_W* inputs.

Parameters:
NUM_REQ, 4, number of requesters; 2..8
DATA_WIDTH, 64, W data width; must equal bridge SDATA_WIDTH
AWPORT_WIDTH, 2, width of the AWPORT field; 2**AWPORT_WIDTH >= NUM_REQ
AWLEN_WIDTH, 16, width of AWLEN, the beat count of the burst (1..2**AWLEN_WIDTH-1)
AWSIZE_WIDTH, 16, width of AWSIZE, the byte count of the burst

Ports:
CLK_I  in  1  clock; same clock as bridge S_CLK_I
RST_I  in  1  synchronous active-high reset
S_AWLEN  in  NUM_REQ*AWLEN_WIDTH  per-requester beat count; requester i uses slice i
S_AWSIZE  in  NUM_REQ*AWSIZE_WIDTH  per-requester byte count
S_AWVALID  in  NUM_REQ  per-requester command valid
S_AWREADY  out  NUM_REQ  per-requester command accepted
S_WVALID  in  NUM_REQ  per-requester beat valid
S_WREADY  out  NUM_REQ  per-requester beat ready
S_WDATA  in  NUM_REQ*DATA_WIDTH  per-requester data
S_WSTRB  in  NUM_REQ*DATA_WIDTH/8  per-requester byte strobes
S_WLAST  in  NUM_REQ  per-requester last beat
M_AWPORT  out  AWPORT_WIDTH  granted requester index
M_AWLEN  out  AWLEN_WIDTH  forwarded beat count
M_AWSIZE  out  AWSIZE_WIDTH  forwarded byte count
M_AWVALID  out  1  to bridge S_AWVALID
M_AWREADY  in  1  from bridge S_AWREADY
M_WVALID  out  1  to bridge S_WVALID
M_WREADY  in  1  from bridge S_WREADY
M_WDATA  out  DATA_WIDTH  to bridge S_WDATA
M_WSTRB  out  DATA_WIDTH/8  to bridge S_WSTRB
M_WLAST  out  1  to bridge S_WLAST
GRANT_O  out  NUM_REQ  one-hot current grant; 0 in IDLE
BUSY_O  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0. All M_* and S_*READY outputs 0. GRANT_O=0, BUSY_O=0. Reset mid-burst abandons the burst immediately. The requester must restart its AW.
- States:
  - IDLE: if any S_AWVALID, select the first asserted index at or after rr_ptr (modulo NUM_REQ). Register grant and go to CMD on the next edge. Total latency is 1 cycle from S_AWVALID to M_AWVALID.
  - CMD: M_AWVALID = S_AWVALID[g]. M_AWPORT = g. M_AWLEN/M_AWSIZE = slice g. S_AWREADY[g] = M_AWREADY. On the handshake, go to DATA.
  - DATA: combinational W mux from requester g: M_WVALID, M_WDATA, M_WSTRB and M_WLAST come from slice g, and S_WREADY[g] = M_WREADY. On a handshake with M_WLAST=1: go to IDLE, rr_ptr = (g+1) mod NUM_REQ, grant cleared.
- All non-granted S_AWREADY/S_WREADY are 0. M_* outputs are 0 when not in the relevant state.
- Withdrawn request: if S_AWVALID[g] drops in CMD before the handshake, return to IDLE without advancing rr_ptr.
- Zero-beat bursts are illegal: AWLEN=0 is forwarded unchecked.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,...
- Minimum per-packet overhead is 2 idle-ish cycles (IDLE plus CMD) when M_AWREADY is held high.
- Back-to-back: a new arbitration starts in the cycle after the WLAST handshake.

Optional Feature:
ARB_BEAT_CHECK_EN
- Defined: a beat counter in DATA compares against the latched AWLEN.
  - If WLAST is handshaken with count != AWLEN, or count reaches AWLEN without WLAST, pulse a 1-cycle ERR_O output.
  - A sticky ERR_STICKY_O output is cleared only by reset.
  - In the second case the arbiter forces M_WLAST=1 on the AWLEN-th beat and releases the grant.
- Undefined: no counter is built and ERR_O/ERR_STICKY_O are not present. WLAST alone terminates the burst.

Decomposition:
- Shared package axis_serdes_pkg: state encoding (IDLE/CMD/DATA) and a clog2 function.
- Sub-module rr_arbiter_comb: combinational round-robin pick of (req vector, rr_ptr) -> (valid, index). Reused by the other bridges.

Test Plan:
- Single requester 2 with AWLEN=2, AWSIZE=11, two beats 64'hee0700aa0100a5a5 and 64'h0000000000CC0201 (strb 8'hFF, 8'h07) -> M_AWPORT=2, identical beats on M_W*, WLAST on beat 2, GRANT_O back to 0.
- All 4 requesters assert simultaneously, M_*READY=1 -> grant order 0,1,2,3, and then 0 again after requester 0 re-requests.
- M_WREADY toggled 1-0-1 during a 3-beat burst -> S_WREADY[g] mirrors it, no beat dropped or duplicated, and other requesters stay stalled.
- RST_I asserted for 1 cycle in DATA after beat 1 -> all outputs 0 next cycle, and rr_ptr=0.
- S_AWVALID[1] withdrawn in CMD while M_AWREADY=0 -> return to IDLE, rr_ptr unchanged, and requester 3 granted next.
- ARB_BEAT_CHECK_EN with AWLEN=3 and WLAST on beat 2 -> ERR_O pulse, ERR_STICKY_O=1, grant released.
